// File: rtl/arc4_sched.sv
// arc4_sched: runs init -> ksa -> prga through en/rdy handshakes and grants single-port S to one owner.
// Define ARC4_SCHED_CHECK_EN to enable the sticky protocol-violation flag on err (tied 0 otherwise).
module arc4_sched #(
  parameter int KEY_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             rdy,
  input  logic [KEY_W-1:0] key,
  output logic [KEY_W-1:0] key_q,
  output logic [1:0]       phase,
  output logic             en_init,
  output logic             en_ksa,
  output logic             en_prga,
  input  logic             rdy_init,
  input  logic             rdy_ksa,
  input  logic             rdy_prga,
  input  logic [7:0]       addr_init,
  input  logic [7:0]       addr_ksa,
  input  logic [7:0]       addr_prga,
  input  logic [7:0]       wrdata_init,
  input  logic [7:0]       wrdata_ksa,
  input  logic [7:0]       wrdata_prga,
  input  logic             wren_init,
  input  logic             wren_ksa,
  input  logic             wren_prga,
  output logic [7:0]       s_addr,
  output logic [7:0]       s_wrdata,
  output logic             s_wren,
  output logic             err
);

  typedef enum logic [2:0] {
    IDLE, INIT_GO, INIT_WAIT, KSA_GO, KSA_WAIT, PRGA_GO, PRGA_WAIT
  } state_t;

  state_t           state_q, state_d;
  logic [KEY_W-1:0] key_d;
  logic [1:0]       phase_d;

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    en_init = 1'b0;
    en_ksa  = 1'b0;
    en_prga = 1'b0;
    unique case (state_q)
      IDLE:      if (en) begin
                   state_d = INIT_GO;
                   key_d   = key;
                 end
      INIT_GO:   begin
                   en_init = rdy_init;
                   if (rdy_init) state_d = INIT_WAIT;
                 end
      INIT_WAIT: if (rdy_init) state_d = KSA_GO;
      KSA_GO:    begin
                   en_ksa = rdy_ksa;
                   if (rdy_ksa) state_d = KSA_WAIT;
                 end
      KSA_WAIT:  if (rdy_ksa) state_d = PRGA_GO;
      PRGA_GO:   begin
                   en_prga = rdy_prga;
                   if (rdy_prga) state_d = PRGA_WAIT;
                 end
      PRGA_WAIT: if (rdy_prga) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Owner is decoded from the next state so the grant moves on the same edge the WAIT state exits.
  always_comb begin
    phase_d = 2'd0;
    unique case (state_d)
      INIT_GO, INIT_WAIT: phase_d = 2'd1;
      KSA_GO, KSA_WAIT:   phase_d = 2'd2;
      PRGA_GO, PRGA_WAIT: phase_d = 2'd3;
      default:            phase_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      rdy     <= 1'b1;
      phase   <= 2'd0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      rdy     <= (state_d == IDLE);
      phase   <= phase_d;
    end
  end

  always_comb begin
    s_addr   = '0;
    s_wrdata = '0;
    s_wren   = 1'b0;
    unique case (phase)
      2'd1: begin
        s_addr   = addr_init;
        s_wrdata = wrdata_init;
        s_wren   = wren_init;
      end
      2'd2: begin
        s_addr   = addr_ksa;
        s_wrdata = wrdata_ksa;
        s_wren   = wren_ksa;
      end
      2'd3: begin
        s_addr   = addr_prga;
        s_wrdata = wrdata_prga;
        s_wren   = wren_prga;
      end
      default: ;
    endcase
  end

`ifdef ARC4_SCHED_CHECK_EN
  logic err_q, err_d;
  logic first_wait_q;
  logic owner_rdy, foreign_wren;

  always_comb begin
    owner_rdy = 1'b0;
    unique case (phase)
      2'd1:    owner_rdy = rdy_init;
      2'd2:    owner_rdy = rdy_ksa;
      2'd3:    owner_rdy = rdy_prga;
      default: owner_rdy = 1'b0;
    endcase
    foreign_wren = (wren_init && phase != 2'd1) ||
                   (wren_ksa  && phase != 2'd2) ||
                   (wren_prga && phase != 2'd3);
    err_d = err_q || foreign_wren || (first_wait_q && owner_rdy);
  end

  // A start pulse is issued exactly on the GO->WAIT transition, so it marks the first WAIT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q        <= 1'b0;
      first_wait_q <= 1'b0;
    end else begin
      err_q        <= err_d;
      first_wait_q <= en_init || en_ksa || en_prga;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_arc4_sched.sv
// Self-checking bench for arc4_sched with behavioural stub engines and a queue-based pulse/latency scoreboard.
module tb_arc4_sched;
  localparam int KW = 24;
`ifdef ARC4_SCHED_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, en, rdy;
  logic [KW-1:0] key, key_q;
  logic [1:0]    phase;
  logic          en_init, en_ksa, en_prga;
  logic          rdy_init, rdy_ksa, rdy_prga;
  logic [7:0]    addr_init, addr_ksa, addr_prga;
  logic [7:0]    wrdata_init, wrdata_ksa, wrdata_prga;
  logic          wren_init, wren_ksa, wren_prga;
  logic [7:0]    s_addr, s_wrdata;
  logic          s_wren, err;

  int n_tests = 0;
  int n_fail  = 0;

  int lat_i = 1, lat_k = 1, lat_p = 1;
  int cnt_i = 0, cnt_k = 0, cnt_p = 0;
  bit hold_k = 1'b0;
  bit force_i = 1'b0;

  logic [1:0] ph_log  [0:4095];
  logic [2:0] en_log  [0:4095];
  logic       wr_log  [0:4095];
  logic       rdy_log [0:4095];
  int         pulse_q[$];
  int         exp_pulse[$];
  int         exp_done[$];
  int         key_bad;
  logic [7:0] p_addr, p_exp;
  logic       p_wren;

  always #5 clk = ~clk;

  arc4_sched #(.KEY_W(KW)) dut (
    .clk(clk), .rst(rst), .en(en), .rdy(rdy), .key(key), .key_q(key_q), .phase(phase),
    .en_init(en_init), .en_ksa(en_ksa), .en_prga(en_prga),
    .rdy_init(rdy_init), .rdy_ksa(rdy_ksa), .rdy_prga(rdy_prga),
    .addr_init(addr_init), .addr_ksa(addr_ksa), .addr_prga(addr_prga),
    .wrdata_init(wrdata_init), .wrdata_ksa(wrdata_ksa), .wrdata_prga(wrdata_prga),
    .wren_init(wren_init), .wren_ksa(wren_ksa), .wren_prga(wren_prga),
    .s_addr(s_addr), .s_wrdata(s_wrdata), .s_wren(s_wren), .err(err)
  );

  // Stub engines: rdy drops the cycle after en is sampled and stays low for lat cycles.
  always @(posedge clk) begin
    if (rst) begin
      cnt_i <= 0; cnt_k <= 0; cnt_p <= 0;
    end else begin
      if (cnt_i != 0) cnt_i <= cnt_i - 1; else if (en_init) cnt_i <= lat_i;
      if (cnt_k != 0) cnt_k <= cnt_k - 1; else if (en_ksa)  cnt_k <= lat_k;
      if (cnt_p != 0) cnt_p <= cnt_p - 1; else if (en_prga) cnt_p <= lat_p;
    end
  end

  assign rdy_init    = (cnt_i == 0);
  assign rdy_ksa     = (cnt_k == 0) && !hold_k;
  assign rdy_prga    = (cnt_p == 0);
  assign addr_init   = force_i ? 8'hAA : (8'h11 ^ cnt_i[7:0]);
  assign wrdata_init = cnt_i[7:0];
  assign wren_init   = force_i || (cnt_i != 0);
  assign addr_ksa    = 8'h5A ^ cnt_k[7:0];
  assign wrdata_ksa  = 8'hC3 ^ cnt_k[7:0];
  assign wren_ksa    = (cnt_k != 0);
  assign addr_prga   = 8'h77 ^ cnt_p[7:0];
  assign wrdata_prga = 8'h3C ^ cnt_p[7:0];
  assign wren_prga   = (cnt_p != 0);

  // Drives one request and records per-cycle observations; cycle 0 is the cycle en is presented.
  task automatic run(input logic [KW-1:0] k, input int li, input int lk, input int lp,
                     input int hold_lo, input int hold_hi, input int probe, input int rst_at,
                     input int busy_at, input int tail, output int done);
    int cyc;
    int left;
    lat_i = li; lat_k = lk; lat_p = lp;
    pulse_q.delete();
    key_bad = 0;
    done = -1;
    left = -1;
    @(negedge clk);
    key = k;
    en = 1'b1;
    cyc = 0;
    hold_k = (cyc >= hold_lo && cyc <= hold_hi);
    for (int guard = 0; guard < 4000; guard++) begin
      @(posedge clk);
      #1;
      cyc++;
      en = (cyc == busy_at);
      if (cyc == busy_at) key = ~k;
      hold_k  = (cyc >= hold_lo && cyc <= hold_hi);
      force_i = (cyc == probe);
      rst     = (cyc == rst_at);
      @(negedge clk);
      ph_log[cyc]  = phase;
      en_log[cyc]  = {en_prga, en_ksa, en_init};
      wr_log[cyc]  = s_wren;
      rdy_log[cyc] = rdy;
      if (en_init) pulse_q.push_back(1);
      if (en_ksa)  pulse_q.push_back(2);
      if (en_prga) pulse_q.push_back(3);
      if (rst_at < 0 && key_q !== k) key_bad++;
      if (cyc == probe) begin
        p_addr = s_addr;
        p_wren = s_wren;
        p_exp  = addr_ksa;
      end
      if (done < 0 && rdy === 1'b1) begin
        done = cyc;
        left = tail;
      end
      if (cyc == rst_at + 1) left = 0;
      if (left == 0) break;
      if (left > 0) left--;
    end
    en = 1'b0; hold_k = 1'b0; force_i = 1'b0; rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b0; key = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_tests++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL reset_rdy: got %b expected 1", rdy); end
    n_tests++; if (phase !== 2'd0) begin n_fail++; $display("FAIL reset_phase: got %0d expected 0", phase); end
    n_tests++; if (s_wren !== 1'b0) begin n_fail++; $display("FAIL reset_s_wren: got %b expected 0", s_wren); end
    n_tests++; if ({en_prga, en_ksa, en_init} !== 3'b000) begin n_fail++; $display("FAIL reset_en: got %b expected 000", {en_prga, en_ksa, en_init}); end
    n_tests++; if (s_addr !== 8'h00 || s_wrdata !== 8'h00) begin n_fail++; $display("FAIL reset_s_bus: got %h/%h expected 00/00", s_addr, s_wrdata); end
    n_tests++; if (key_q !== 24'h0) begin n_fail++; $display("FAIL reset_key_q: got %h expected 000000", key_q); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
  endtask

  task automatic test_full_run;
    int done, e, o;
    exp_pulse.push_back(1); exp_pulse.push_back(2); exp_pulse.push_back(3);
    exp_done.push_back(1543);
    run(24'h00033C, 256, 768, 512, -1, -1, -1, -1, -1, 3, done);
    n_tests++; if (pulse_q.size() != exp_pulse.size()) begin n_fail++; $display("FAIL full_pulse_count: got %0d expected %0d", pulse_q.size(), exp_pulse.size()); end
    while (exp_pulse.size() > 0 && pulse_q.size() > 0) begin
      e = exp_pulse.pop_front(); o = pulse_q.pop_front();
      n_tests++; if (o != e) begin n_fail++; $display("FAIL full_pulse_order: got %0d expected %0d", o, e); end
    end
    exp_pulse.delete();
    e = exp_done.pop_front();
    n_tests++; if (done != e) begin n_fail++; $display("FAIL full_latency: got %0d expected %0d", done, e); end
    n_tests++; if (en_log[1] !== 3'b001) begin n_fail++; $display("FAIL full_en_init_cyc1: got %b expected 001", en_log[1]); end
    n_tests++; if (en_log[259] !== 3'b010) begin n_fail++; $display("FAIL full_en_ksa_cyc259: got %b expected 010", en_log[259]); end
    n_tests++; if (en_log[1029] !== 3'b100) begin n_fail++; $display("FAIL full_en_prga_cyc1029: got %b expected 100", en_log[1029]); end
    n_tests++; if (ph_log[1542] !== 2'd3 || ph_log[1543] !== 2'd0) begin n_fail++; $display("FAIL full_phase_end: got %0d,%0d expected 3,0", ph_log[1542], ph_log[1543]); end
    n_tests++; if (key_bad != 0) begin n_fail++; $display("FAIL full_key_q: got %0d bad cycles expected 0", key_bad); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL full_err: got %b expected 0", err); end
  endtask

  task automatic test_delayed_ready;
    int done, e, o;
    exp_pulse.push_back(1); exp_pulse.push_back(2); exp_pulse.push_back(3);
    exp_done.push_back(27);
    run(24'h123456, 4, 6, 5, 0, 11, -1, -1, -1, 0, done);
    for (int c = 7; c <= 11; c++) begin
      n_tests++; if (en_log[c][1] !== 1'b0 || ph_log[c] !== 2'd2) begin n_fail++; $display("FAIL delay_hold_c%0d: got en_ksa=%b phase=%0d expected 0,2", c, en_log[c][1], ph_log[c]); end
    end
    n_tests++; if (en_log[12] !== 3'b010 || ph_log[12] !== 2'd2) begin n_fail++; $display("FAIL delay_pulse: got en=%b phase=%0d expected 010,2", en_log[12], ph_log[12]); end
    n_tests++; if (pulse_q.size() != exp_pulse.size()) begin n_fail++; $display("FAIL delay_pulse_count: got %0d expected %0d", pulse_q.size(), exp_pulse.size()); end
    while (exp_pulse.size() > 0 && pulse_q.size() > 0) begin
      e = exp_pulse.pop_front(); o = pulse_q.pop_front();
      n_tests++; if (o != e) begin n_fail++; $display("FAIL delay_pulse_order: got %0d expected %0d", o, e); end
    end
    exp_pulse.delete();
    e = exp_done.pop_front();
    n_tests++; if (done != e) begin n_fail++; $display("FAIL delay_latency: got %0d expected %0d", done, e); end
  endtask

  task automatic test_mux_isolation;
    int done, e;
    exp_done.push_back(36);
    run(24'h0000FF, 4, 20, 5, -1, -1, 12, -1, -1, 0, done);
    n_tests++; if (p_addr !== p_exp) begin n_fail++; $display("FAIL mux_s_addr: got %h expected %h", p_addr, p_exp); end
    n_tests++; if (p_wren !== 1'b1) begin n_fail++; $display("FAIL mux_s_wren: got %b expected 1", p_wren); end
    n_tests++; if (ph_log[12] !== 2'd2) begin n_fail++; $display("FAIL mux_phase: got %0d expected 2", ph_log[12]); end
    n_tests++; if (err !== CHK) begin n_fail++; $display("FAIL mux_err: got %b expected %b", err, CHK); end
    e = exp_done.pop_front();
    n_tests++; if (done != e) begin n_fail++; $display("FAIL mux_latency: got %0d expected %0d", done, e); end
  endtask

  task automatic test_reset_mid_ksa;
    int done;
    run(24'h0ABCDE, 256, 768, 512, -1, -1, -1, 400, -1, 0, done);
    n_tests++; if (ph_log[400] !== 2'd2 || wr_log[400] !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre: got phase=%0d s_wren=%b expected 2,1", ph_log[400], wr_log[400]); end
    n_tests++; if (ph_log[401] !== 2'd0) begin n_fail++; $display("FAIL rstmid_phase: got %0d expected 0", ph_log[401]); end
    n_tests++; if (wr_log[401] !== 1'b0) begin n_fail++; $display("FAIL rstmid_s_wren: got %b expected 0", wr_log[401]); end
    n_tests++; if (rdy_log[401] !== 1'b1) begin n_fail++; $display("FAIL rstmid_rdy: got %b expected 1", rdy_log[401]); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL rstmid_err: got %b expected 0", err); end
    exp_done.push_back(16);
    run(24'h000777, 3, 3, 3, -1, -1, -1, -1, -1, 0, done);
    n_tests++; if (en_log[1] !== 3'b001 || ph_log[1] !== 2'd1) begin n_fail++; $display("FAIL rstmid_restart: got en=%b phase=%0d expected 001,1", en_log[1], ph_log[1]); end
    n_tests++; if (done != exp_done.pop_front()) begin n_fail++; $display("FAIL rstmid_restart_latency: got %0d expected 16", done); end
  endtask

  task automatic test_busy_request;
    int done;
    exp_done.push_back(22);
    run(24'h00033C, 4, 6, 5, -1, -1, -1, -1, 17, 10, done);
    n_tests++; if (ph_log[17] !== 2'd3) begin n_fail++; $display("FAIL busy_phase: got %0d expected 3", ph_log[17]); end
    n_tests++; if (done != exp_done.pop_front()) begin n_fail++; $display("FAIL busy_latency: got %0d expected 22", done); end
    n_tests++; if (pulse_q.size() != 3) begin n_fail++; $display("FAIL busy_single_run: got %0d pulses expected 3", pulse_q.size()); end
    n_tests++; if (done > 0 && rdy_log[done + 10] !== 1'b1) begin n_fail++; $display("FAIL busy_stays_idle: got rdy=%b expected 1", rdy_log[done + 10]); end
    n_tests++; if (key_q !== 24'h00033C) begin n_fail++; $display("FAIL busy_key_q: got %h expected 00033C", key_q); end
    n_tests++; if (key_bad != 0) begin n_fail++; $display("FAIL busy_key_hold: got %0d bad cycles expected 0", key_bad); end
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_delayed_ready();
    test_mux_isolation();
    test_reset_mid_ksa();
    test_busy_request();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
